// File: rtl/mat_result_unloader.sv
// mat_result_unloader: streams a frame of complex results from an upstream store as valid/ready beats.
module mat_result_unloader #(
  parameter int N_PAIR    = 256,
  parameter int IM_OFFSET = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flag_sub,
  input  logic signed [31:0] sum,
  output logic        [31:0] index,
  output logic signed [31:0] out_re,
  output logic signed [31:0] out_im,
  output logic        [1:0]  out_row,
  output logic        [5:0]  out_col,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, RE_ADDR, IM_ADDR, IM_CAP, OUT_HOLD, DONE} state_t;
  localparam logic [31:0] LAST_N = 32'(N_PAIR - 1);
  localparam logic [31:0] OFF = 32'(IM_OFFSET);
  state_t state, state_d;
  logic [31:0] n, n_d, index_d;
  logic signed [31:0] re_q, re_d, re_out_d, im_out_d;
  logic [1:0] row_d;
  logic [5:0] col_d;
  logic valid_d, last_d;
  assign busy = state inside {RE_ADDR, IM_ADDR, IM_CAP, OUT_HOLD};
  assign done = state == DONE;
  always_comb begin
    state_d  = state;
    n_d      = n;
    re_d     = re_q;
    re_out_d = out_re;
    im_out_d = out_im;
    row_d    = out_row;
    col_d    = out_col;
    valid_d  = out_valid;
    last_d   = out_last;
    case (state)
      IDLE: if (flag_sub) begin
        state_d = RE_ADDR;
        n_d     = '0;
      end
      RE_ADDR: state_d = IM_ADDR;
      IM_ADDR: begin
        state_d = IM_CAP;
        re_d    = sum;
      end
      IM_CAP: begin
        state_d  = OUT_HOLD;
        re_out_d = re_q;
        im_out_d = sum;
        row_d    = n[7:6];
        col_d    = n[5:0];
        last_d   = n == LAST_N;
        valid_d  = 1'b1;
      end
      OUT_HOLD: if (out_valid && out_ready) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = (n == LAST_N) ? DONE : RE_ADDR;
        n_d     = (n == LAST_N) ? n : n + 32'd1;
      end
      default: ;
    endcase
    // losing the ready flag mid-frame abandons the frame rather than stalling it
    if (busy && !flag_sub) begin
      state_d = IDLE;
      n_d     = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    index_d = (state_d == RE_ADDR) ? n_d : (state_d == IM_ADDR) ? n_d + OFF : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      n         <= '0;
      index     <= '0;
      re_q      <= '0;
      out_re    <= '0;
      out_im    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      n         <= n_d;
      index     <= index_d;
      re_q      <= re_d;
      out_re    <= re_out_d;
      out_im    <= im_out_d;
      out_row   <= row_d;
      out_col   <= col_d;
      out_valid <= valid_d;
      out_last  <= last_d;
    end
  end
endmodule

// File: tb/tb_mat_result_unloader.sv
// tb_mat_result_unloader: scoreboard bench with an upstream memory model and randomized back-pressure.
module tb_mat_result_unloader;
  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [1:0]  row;
    logic [5:0]  col;
    logic        last;
  } beat_t;
  logic clk = 0, rst = 0, flag_sub = 0, out_ready = 1;
  logic signed [31:0] sum = 0;
  logic [31:0] index;
  logic signed [31:0] out_re, out_im;
  logic [1:0] out_row;
  logic [5:0] out_col;
  logic out_valid, out_last, busy, done;
  logic [31:0] mem [0:1023];
  beat_t q[$];
  beat_t cur, prev, e;
  int tests = 0, fails = 0, accepted = 0;
  bit rand_ready = 0, pv = 0, pr = 0;
  mat_result_unloader dut (
    .clk(clk), .rst(rst), .flag_sub(flag_sub), .sum(sum), .index(index),
    .out_re(out_re), .out_im(out_im), .out_row(out_row), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) sum <= mem[index[9:0]];
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = $urandom_range(0, 2) != 0;
  end
  assign cur = '{out_re, out_im, out_row, out_col, out_last};
  always @(negedge clk) begin
    if (rst && flag_sub && out_valid && pv && !pr) begin
      tests++;
      if (cur !== prev) begin
        fails++;
        $display("FAIL hold: got %h expected %h", cur, prev);
      end
    end
    if (rst && flag_sub && out_valid && out_ready) begin
      tests++;
      accepted++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL beat: got unexpected %h expected none", cur);
      end else begin
        e = q.pop_front();
        if (cur !== e) begin
          fails++;
          $display("FAIL beat: got re=%h im=%h row=%0d col=%0d last=%b expected re=%h im=%h row=%0d col=%0d last=%b",
                   out_re, out_im, out_row, out_col, out_last, e.re, e.im, e.row, e.col, e.last);
        end
      end
    end
    pv = rst && flag_sub && out_valid;
    pr = out_ready;
    prev = cur;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push_frame();
    q.delete();
    for (int n = 0; n < 256; n++)
      q.push_back('{mem[n], mem[n + 256], 2'(n / 64), 6'(n % 64), n == 255});
  endtask
  task automatic rand_mem();
    for (int k = 0; k < 1024; k++) mem[k] = $urandom;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_index"}, index, 0);
    chk({tag, "_re"}, out_re, 0);
    chk({tag, "_im"}, out_im, 0);
    chk({tag, "_row"}, 32'(out_row), 0);
    chk({tag, "_col"}, 32'(out_col), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_last"}, 32'(out_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask
  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 5000) begin
      tick();
      t++;
    end
    chk({tag, "_done_timeout"}, 32'(done), 1);
    tick();
    chk({tag, "_queue_left"}, q.size(), 0);
  endtask
  task automatic wait_accepted(input int target, input string tag);
    int t = 0;
    while (accepted < target && t < 5000) begin
      tick();
      t++;
    end
    chk({tag, "_beats_timeout"}, 32'(accepted >= target), 1);
  endtask
  task automatic restart_checks(input string tag);
    tick();
    chk({tag, "_idx0"}, index, 0);
    chk({tag, "_busy0"}, 32'(busy), 1);
    tick();
    chk({tag, "_idx1"}, index, 256);
  endtask
  initial begin
    int cyc, base, t;
    for (int k = 0; k < 1024; k++) mem[k] = k;
    repeat (3) tick();
    check_zero("reset");
    // full frame, identity store, ready held high
    push_frame();
    rst = 1;
    tick();
    flag_sub = 1;
    cyc = 0;
    t = 0;
    while (!done && t < 3000) begin
      tick();
      if (busy) cyc++;
      t++;
    end
    chk("frame_done", 32'(done), 1);
    chk("frame_cycles", cyc, 1024);
    chk("frame_beats", accepted, 256);
    chk("frame_queue", q.size(), 0);
    // done is sticky and blocks replay
    base = accepted;
    flag_sub = 0;
    repeat (3) tick();
    flag_sub = 1;
    repeat (20) tick();
    chk("sticky_done", 32'(done), 1);
    chk("sticky_busy", 32'(busy), 0);
    chk("sticky_index", index, 0);
    chk("sticky_beats", accepted, base);
    // negative data bit-exact plus a 10-cycle stall on beat 5
    rst = 0;
    flag_sub = 0;
    rand_mem();
    mem[0] = 32'hFFFF_FFF0;
    mem[256] = 32'h8000_0000;
    mem[5] = 5;
    mem[261] = 261;
    tick();
    push_frame();
    rst = 1;
    accepted = 0;
    flag_sub = 1;
    wait_accepted(1, "neg");
    chk("neg_beats", accepted, 1);
    wait_accepted(5, "stall");
    out_ready = 0;
    t = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_re", out_re, 5);
      chk("stall_im", out_im, 261);
      chk("stall_rowcol", {out_row, out_col}, 5);
      tick();
    end
    chk("stall_count", accepted, 5);
    rand_ready = 1;
    wait_done("stall");
    // reset during beat 100's hold, flag_sub left high
    rand_ready = 0;
    out_ready = 1;
    rst = 0;
    rand_mem();
    tick();
    push_frame();
    rst = 1;
    accepted = 0;
    wait_accepted(100, "rst_mid");
    out_ready = 0;
    t = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    chk("rst_mid_pending", 32'(out_valid), 1);
    rst = 0;
    tick();
    check_zero("rst_mid");
    push_frame();
    out_ready = 1;
    rst = 1;
    restart_checks("rst_restart");
    rand_ready = 1;
    wait_done("rst_restart");
    // flag_sub dropped in beat 3's imaginary-address cycle
    rand_ready = 0;
    out_ready = 1;
    rst = 0;
    rand_mem();
    tick();
    push_frame();
    rst = 1;
    accepted = 0;
    t = 0;
    while (!(accepted == 3 && index == 259) && t < 100) begin
      tick();
      t++;
    end
    chk("abort_reached", index, 259);
    flag_sub = 0;
    tick();
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_last", 32'(out_last), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_index", index, 0);
    push_frame();
    flag_sub = 1;
    restart_checks("abort_restart");
    rand_ready = 1;
    wait_done("abort_restart");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mat_result_unloader.md
MAT_RESULT_UNLOADER -- requirements
Module: mat_result_unloader

Interface
REQ-001 SHALL have parameter N_PAIR, default 256, meaning the number of complex results per frame (4 rows x 64 columns).
REQ-002 SHALL have parameter IM_OFFSET, default 256, meaning the word distance between a result's real part and its imaginary part in the upstream result store.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port flag_sub, input, 1 bit: upstream multiplier results ready (level).
REQ-006 SHALL have port sum, input, 32 bits signed: upstream read data; equals the stored word selected by index, one cycle after index is presented.
REQ-007 SHALL have port index, output, 32 bits: registered read address to upstream.
REQ-008 SHALL have port out_re, output, 32 bits signed: real part of the current result.
REQ-009 SHALL have port out_im, output, 32 bits signed: imaginary part of the current result.
REQ-010 SHALL have port out_row, output, 2 bits: result row (n[7:6]).
REQ-011 SHALL have port out_col, output, 6 bits: result column (n[5:0]).
REQ-012 SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-014 SHALL have port out_last, output, 1 bit: final beat of the frame.
REQ-015 SHALL have port busy, output, 1 bit: unload in progress.
REQ-016 SHALL have port done, output, 1 bit: frame fully delivered (sticky).

Function
REQ-017 SHALL implement FSM states IDLE, RE_ADDR, IM_ADDR, IM_CAP, OUT_HOLD and DONE, and SHALL keep a pair counter n, 0..N_PAIR-1.
REQ-018 SHALL move IDLE -> RE_ADDR when flag_sub=1, clearing n to 0; otherwise SHALL stay in IDLE with index=0.
REQ-019 RE_ADDR SHALL hold index=n for one cycle, then go to IM_ADDR.
REQ-020 IM_ADDR SHALL hold index=n+IM_OFFSET, SHALL capture sum into an internal real register at the end of the cycle, then go to IM_CAP.
REQ-021 IM_CAP SHALL, at the end of the cycle, load out_im<=sum, out_re<=real register, out_row/out_col from n, out_last<=(n==N_PAIR-1), out_valid<=1, then go to OUT_HOLD.
REQ-022 OUT_HOLD SHALL keep all out_* stable while out_valid=1 and out_ready=0.
REQ-023 On out_valid & out_ready, OUT_HOLD SHALL drop out_valid next cycle; SHALL go to DONE if n==N_PAIR-1, else increment n and go to RE_ADDR.
REQ-024 out_valid SHALL NOT depend combinationally on out_ready; out_ready=1 before out_valid SHALL have no effect.
REQ-025 Minimum beat period SHALL be 4 cycles (RE_ADDR, IM_ADDR, IM_CAP, OUT_HOLD with ready=1); a frame with ready held at 1 SHALL take 4*N_PAIR cycles from leaving IDLE to entering DONE.
REQ-026 busy SHALL be 1 in RE_ADDR, IM_ADDR, IM_CAP and OUT_HOLD, and 0 otherwise.
REQ-027 DONE SHALL assert done=1, hold index=0, and ignore flag_sub, so a frame is never replayed; only rst SHALL leave DONE.
REQ-028 If flag_sub falls while busy, the block SHALL abort to IDLE next cycle: out_valid=0, out_last=0, done=0, n=0.
REQ-029 sum SHALL be passed through bit-exact, with no rescaling, rounding or saturation.
REQ-030 out_last SHALL be 1 only on the beat with row=3, col=63.

Reset
REQ-031 When rst=0 at a clock edge, the block SHALL go to IDLE and clear n to 0.
REQ-032 When rst=0 at a clock edge, the block SHALL set index=0, out_re=0, out_im=0, out_row=0, out_col=0, out_valid=0, out_last=0, busy=0 and done=0.
REQ-033 rst SHALL override all other inputs, including mid-frame and while a beat is pending.

Verification
REQ-034 Upstream model with word k = k, flag_sub=1, out_ready=1 -> 256 beats; beat n has re=n, im=n+256; out_last only on beat 255; done=1 exactly 1024 cycles after leaving IDLE.
REQ-035 Same model, out_ready held 0 for 10 cycles on beat 5 -> out_re=5, out_im=261, row=0, col=5 stable for all 10 cycles; no beat lost or duplicated.
REQ-036 Negative data: word 0 = 0xFFFFFFF0, word 256 = 0x80000000 -> first beat re=0xFFFFFFF0, im=0x80000000, bit-exact.
REQ-037 rst=0 asserted during beat 100's OUT_HOLD -> next cycle all outputs 0 and state IDLE; with flag_sub still 1 a new frame restarts at n=0 (index=0, then 256).
REQ-038 flag_sub dropped during IM_ADDR of beat 3 -> IDLE, out_valid=0, done=0; flag_sub=1 again -> restarts at n=0.
REQ-039 After done=1, flag_sub toggled 0 -> 1 -> done stays 1, busy stays 0, index stays 0, and no further beats are produced.
